// File: rtl/ram_rd_transpose_pkg.sv
// Shared DCT types and sizing for the transpose-buffer read engine.
// PINGPONG_EN doubles the RAM depth so two blocks alternate banks.
package ram_rd_transpose_pkg;

    localparam int DCT_N      = 8;
    localparam int DCT_DATA_W = 10;

`ifdef PINGPONG_EN
    localparam int DCT_DEPTH  = 2 * DCT_N * DCT_N;
`else
    localparam int DCT_DEPTH  = DCT_N * DCT_N;
`endif
    localparam int DCT_ADDR_W = $clog2(DCT_DEPTH);

    typedef struct packed {
        logic [DCT_DATA_W-1:0] data;
        logic                  valid;
    } dctPort_t;

endpackage

// File: rtl/ram_rd_transpose_if.sv
// Control, RAM read port and output stream of the transpose read engine.
// PINGPONG_EN adds the rd_bank indicator.
interface ram_rd_transpose_if
    import ram_rd_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_W,
    parameter int AW         = DCT_ADDR_W
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [AW-1:0]         rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
`ifdef PINGPONG_EN
    logic                  rd_bank;
`endif

    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_addr, rd_en, out_data, out_valid, out_last
`ifdef PINGPONG_EN
        , rd_bank
`endif
    );

    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_addr, rd_en, out_data, out_valid, out_last
`ifdef PINGPONG_EN
        , rd_bank
`endif
    );

endinterface

// File: rtl/ram_rd_transpose_rd_skid_fifo.sv
// 2-entry synchronous FIFO that absorbs the 1-cycle RAM read latency.
// Caller guarantees no push when full and no pop when empty.
module ram_rd_transpose_rd_skid_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_rd_transpose.sv
// Column-major read engine for the 8x8 DCT transpose buffer.
// PINGPONG_EN: alternate between two N*N banks, toggling on each done.
module ram_rd_transpose
    import ram_rd_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_W,
    parameter int N          = DCT_N
) (
    input  logic clk,
    input  logic rst_n,
    ram_rd_transpose_if.master bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(N * N);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       r;
    logic [CW-1:0]       c;
    logic                inflight;
    logic                inflight_last;
    logic                issue_last;
    logic                rd_en;
    logic                pop;
    logic                done;
    logic [1:0]          occ;
    logic [DATA_WIDTH:0] head;
    logic [BW-1:0]       base_addr;
    dctPort_t            out_port;
`ifdef PINGPONG_EN
    logic                bank;
`endif

    assign issue_last = (r == CW'(N - 1)) && (c == CW'(N - 1));
    assign out_port   = '{data: head[DATA_WIDTH-1:0], valid: (occ != 2'd0)};
    assign pop        = out_port.valid && bus.out_ready;
    // Credit: entries held plus the read in flight, net of this cycle's pop, must leave a slot.
    assign rd_en      = (state == ISSUE) &&
                        (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign done       = (state == DRAIN) && pop && head[DATA_WIDTH];
    assign base_addr  = BW'(r) * BW'(N) + BW'(c);

`ifdef PINGPONG_EN
    assign bus.rd_addr = {bank, base_addr};
    assign bus.rd_bank = bank;
`else
    assign bus.rd_addr = base_addr;
`endif
    assign bus.rd_en     = rd_en;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.out_valid = out_port.valid;
    assign bus.out_data  = out_port.data;
    assign bus.out_last  = out_port.valid && head[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            r             <= '0;
            c             <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef PINGPONG_EN
            bank          <= 1'b0;
`endif
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && issue_last;
            case (state)
                IDLE: if (bus.start) state <= ISSUE;
                ISSUE: if (rd_en) begin
                    // Row runs fastest so consecutive reads walk down a column.
                    if (r == CW'(N - 1)) begin
                        r <= '0;
                        c <= (c == CW'(N - 1)) ? '0 : c + CW'(1);
                    end else begin
                        r <= r + CW'(1);
                    end
                    if (issue_last) state <= DRAIN;
                end
                DRAIN: if (done) begin
                    state <= IDLE;
`ifdef PINGPONG_EN
                    bank  <= ~bank;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    ram_rd_transpose_rd_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({inflight_last, bus.rd_data}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

endmodule
